// File: rtl/iopad_bank_if.sv
// Fabric-side bundle of the iopad_bank: drive data and direction requests in,
// synchronised pad data plus per-pad status out.
interface iopad_bank_if #(
  parameter int NUM_PADS = 8
);
  logic [NUM_PADS-1:0] outpad;
  logic [NUM_PADS-1:0] en;
  logic [NUM_PADS-1:0] inpad;
  logic [NUM_PADS-1:0] in_valid;
  logic [NUM_PADS-1:0] drive;

  modport master (output outpad, output en, input inpad, input in_valid, input drive);
  modport slave  (input outpad, input en, output inpad, output in_valid, output drive);
endinterface

// File: rtl/iopad_bank.sv
// Registered bank of bidirectional pads with per-pad turnaround FSM, input synchroniser
// and valid qualifier. Optional input keeper: define IOPAD_BANK_KEEPER_EN.
module iopad_bank #(
  parameter int NUM_PADS    = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TURNAROUND  = 2
) (
  input  logic                clk,
  input  logic                reset,
  inout  wire  [NUM_PADS-1:0] pad,
  iopad_bank_if.slave         bus
);

  localparam int CW = $clog2(TURNAROUND + SYNC_STAGES + 1);
  localparam logic [CW-1:0] TURN_LOAD = CW'(TURNAROUND > 0 ? TURNAROUND - 1 : 0);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(TURNAROUND + SYNC_STAGES - 1);
  localparam logic [CW-1:0] SYNC_LOAD = CW'(SYNC_STAGES);

  typedef enum logic [1:0] {ST_IN, ST_WAIT_IN, ST_TURN_OUT, ST_OUT} state_e;

  state_e                              state_q [NUM_PADS];
  state_e                              state_d [NUM_PADS];
  logic   [CW-1:0]                     cnt_q   [NUM_PADS];
  logic   [CW-1:0]                     cnt_d   [NUM_PADS];
  logic   [NUM_PADS-1:0]               out_q;
  logic   [SYNC_STAGES-1:0][NUM_PADS-1:0] sync_q;
  logic   [NUM_PADS-1:0]               oe;
  logic   [NUM_PADS-1:0]               valid;
  logic   [NUM_PADS-1:0]               sync_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= '0;
      sync_q <= '0;
      for (int i = 0; i < NUM_PADS; i++) begin
        state_q[i] <= ST_IN;
        cnt_q[i]   <= '0;
      end
    end else begin
      out_q     <= bus.outpad;
      sync_q[0] <= pad;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      for (int i = 0; i < NUM_PADS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PADS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_IN: begin
          if (!bus.en[i]) begin
            if (TURNAROUND == 0) begin
              state_d[i] = ST_OUT;
            end else begin
              state_d[i] = ST_TURN_OUT;
              cnt_d[i]   = TURN_LOAD;
            end
          end else if (cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
        end
        // Aborting a pending turn-out: the pad was never driven, so only resync.
        ST_TURN_OUT: begin
          if (bus.en[i]) begin
            state_d[i] = ST_IN;
            cnt_d[i]   = SYNC_LOAD;
          end else if (cnt_q[i] == '0) begin
            state_d[i] = ST_OUT;
          end else begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
        end
        ST_OUT: begin
          if (bus.en[i]) begin
            state_d[i] = ST_WAIT_IN;
            cnt_d[i]   = WAIT_LOAD;
          end
        end
        ST_WAIT_IN: begin
          if (!bus.en[i]) begin
            if (TURNAROUND == 0) begin
              state_d[i] = ST_OUT;
            end else begin
              state_d[i] = ST_TURN_OUT;
              cnt_d[i]   = TURN_LOAD;
            end
          end else if (cnt_q[i] == '0) begin
            state_d[i] = ST_IN;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
        end
        default: begin
          state_d[i] = ST_IN;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Valid is gated by reset so the reset-state counter of 0 does not flag valid data.
  always_comb begin
    oe    = '0;
    valid = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      oe[i]    = (state_q[i] == ST_OUT);
      valid[i] = !reset && (state_q[i] == ST_IN) && (cnt_q[i] == '0);
    end
  end

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
    assign pad[g] = oe[g] ? out_q[g] : 1'bz;
  end

  assign sync_last    = sync_q[SYNC_STAGES-1];
  assign bus.drive    = oe;
  assign bus.in_valid = valid;

`ifdef IOPAD_BANK_KEEPER_EN
  logic [NUM_PADS-1:0] hold_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hold_q <= '0;
    else       hold_q <= (valid & sync_last) | (~valid & hold_q);
  end

  assign bus.inpad = (valid & sync_last) | (~valid & hold_q);
`else
  assign bus.inpad = valid & sync_last;
`endif

endmodule

// File: tb/tb_iopad_bank.sv
// Directed bench for iopad_bank (4 pads, 2 sync stages, turnaround 2); expectations hand-derived.
module tb_iopad_bank;
  localparam int N = 4;
`ifdef IOPAD_BANK_KEEPER_EN
  localparam bit KEEP = 1'b1;
`else
  localparam bit KEEP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  wire  [N-1:0] pad;
  logic [N-1:0] ext_oe;
  logic [N-1:0] ext_val;
  int           checks = 0;
  int           errors = 0;

  iopad_bank_if #(.NUM_PADS(N)) bus ();

  iopad_bank #(.NUM_PADS(N), .SYNC_STAGES(2), .TURNAROUND(2)) dut (
    .clk   (clk),
    .reset (reset),
    .pad   (pad),
    .bus   (bus)
  );

  for (genvar g = 0; g < N; g++) begin : g_ext
    assign pad[g] = ext_oe[g] ? ext_val[g] : 1'bz;
  end

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.en     = 4'b1111;
    bus.outpad = 4'b0000;
    ext_oe     = 4'b0000;
    ext_val    = 4'b0000;
    tick(2);
    chk("rst_drive", bus.drive, 4'b0000);
    chk("rst_valid", bus.in_valid, 4'b0000);
    chk("rst_inpad", bus.inpad, 4'b0000);

    // All pads inputs, external 1010
    reset   = 1'b0;
    ext_oe  = 4'b1111;
    ext_val = 4'b1010;
    tick(1);
    chk("in_lat1_inpad", bus.inpad, 4'b0000);
    tick(1);
    chk("in_lat2_inpad", bus.inpad, 4'b1010);
    chk("in_valid_all", bus.in_valid, 4'b1111);
    chk("in_drive_none", bus.drive, 4'b0000);

    // Pad 0 turns to output driving 1
    ext_oe     = 4'b1110;
    bus.en     = 4'b1110;
    bus.outpad = 4'b0001;
    tick(1);
    chk("p0_k_drive", bus.drive, 4'b0000);
    chk("p0_k_valid", bus.in_valid, 4'b1110);
    chk("p0_k_padhi", 32'(pad[0] === 1'b1), 0);
    tick(1);
    chk("p0_k1_drive", bus.drive, 4'b0000);
    chk("p0_k1_padhi", 32'(pad[0] === 1'b1), 0);
    tick(1);
    chk("p0_k2_drive", bus.drive, 4'b0001);
    chk("p0_k2_padhi", 32'(pad[0] === 1'b1), 1);
    chk("p0_k2_inpad", bus.inpad, 4'b1010);

    // Pad 1 to output, then back to input
    ext_oe     = 4'b1100;
    bus.en     = 4'b1100;
    bus.outpad = 4'b0011;
    tick(3);
    chk("p1_out_drive", bus.drive, 4'b0011);
    bus.en = 4'b1110;
    tick(1);
    chk("p1_k_drive", bus.drive, 4'b0001);
    ext_oe  = 4'b1110;
    ext_val = 4'b1010;
    tick(2);
    chk("p1_k2_valid", bus.in_valid, 4'b1100);
    tick(1);
    chk("p1_k3_valid", bus.in_valid, 4'b1100);
    tick(1);
    chk("p1_k4_valid", bus.in_valid, 4'b1110);
    chk("p1_k4_inpad", bus.inpad, 4'b1010);

    // Pad 1 leaves input: keeper holds last value, otherwise 0
    ext_oe = 4'b1100;
    bus.en = 4'b1100;
    tick(1);
    chk("keep_valid", bus.in_valid, 4'b1100);
    chk("keep_inpad", bus.inpad, KEEP ? 4'b1010 : 4'b1000);

    // Pad 2 single-cycle output request never drives
    ext_val = 4'b1110;
    tick(2);
    chk("p2_pre_inpad", 32'(bus.inpad[2]), 1);
    chk("p2_pre_drive", bus.drive, 4'b0011);
    bus.en = 4'b1000;
    tick(1);
    chk("p2_k_drive", bus.drive, 4'b0011);
    chk("p2_k_valid", 32'(bus.in_valid[2]), 0);
    bus.en = 4'b1100;
    tick(1);
    chk("p2_k1_drive", bus.drive, 4'b0011);
    tick(1);
    chk("p2_k2_valid", 32'(bus.in_valid[2]), 0);
    chk("p2_k2_drive", bus.drive, 4'b0011);
    tick(1);
    chk("p2_k3_valid", 32'(bus.in_valid[2]), 1);
    chk("p2_k3_inpad", 32'(bus.inpad[2]), 1);
    chk("p2_k3_drive", bus.drive, 4'b0011);

    // Pad 3 driving 1, then asynchronous reset mid-cycle
    ext_oe     = 4'b0100;
    bus.en     = 4'b0100;
    bus.outpad = 4'b1011;
    tick(3);
    chk("p3_out_drive", bus.drive, 4'b1011);
    chk("p3_out_padhi", 32'(pad[3] === 1'b1), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_drive", bus.drive, 4'b0000);
    chk("arst_padhi", 32'(pad[3] === 1'b1), 0);
    chk("arst_inpad", bus.inpad, 4'b0000);
    chk("arst_valid", bus.in_valid, 4'b0000);
    tick(1);
    reset = 1'b0;
    tick(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
